// File: rtl/word_matcher_pkg.sv
// Shared types and helpers for the multi-slot word matcher.
// Holds the FSM encoding, status codes and character folding.
package word_matcher_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_CHECK,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_WIN  = 2'd2;
    localparam logic [1:0] ST_LOSE = 2'd3;

    localparam int unsigned PH_DEFAULT = 32'h2D;

    function automatic logic [31:0] fold_upper(input logic [31:0] c);
        if (c >= 32'h61 && c <= 32'h7A)
            return c - 32'h20;
        return c;
    endfunction

endpackage

// File: rtl/word_matcher_slot_compare.sv
// One character slot: match against the key and pick the display char.
// Unrevealed slots show the fill character.
module slot_compare #(
    parameter int unsigned            CHAR_W    = 7,
    parameter logic [CHAR_W-1:0]      FILL_CHAR = 7'h2D
) (
    input  logic [CHAR_W-1:0] stored,
    input  logic [CHAR_W-1:0] key,
    input  logic              revealed,
    output logic              match,
    output logic [CHAR_W-1:0] disp
);

    assign match = (stored == key);
    assign disp  = revealed ? stored : FILL_CHAR;

endmodule

// File: rtl/word_matcher.sv
// Guessing-game word matcher: compares each accepted key against all
// slots in parallel, reveals matches and tracks misses to a limit.
import word_matcher_pkg::*;

module word_matcher #(
    parameter int unsigned       WORD_LEN   = 4,
    parameter int unsigned       CHAR_W     = 7,
    parameter int unsigned       MAX_MISSES = 6,
    parameter logic [CHAR_W-1:0] FILL_CHAR  = CHAR_W'(PH_DEFAULT),
    parameter bit                CASE_FOLD  = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [WORD_LEN*CHAR_W-1:0] word_in,
    input  logic                       key_valid,
    input  logic [CHAR_W-1:0]          key,
    output logic                       key_ready,
    output logic [WORD_LEN*CHAR_W-1:0] disp_word,
    output logic [WORD_LEN-1:0]        revealed,
    output logic                       hit,
    output logic                       miss,
    output logic [3:0]                 miss_count,
    output logic [1:0]                 status
);

    localparam logic [3:0] MAX_MC = 4'(MAX_MISSES);

    function automatic logic [CHAR_W-1:0] fold(input logic [CHAR_W-1:0] c);
        return CASE_FOLD ? CHAR_W'(fold_upper(32'(c))) : c;
    endfunction

    state_t                     state;
    logic [WORD_LEN*CHAR_W-1:0] word;
    logic [CHAR_W-1:0]          key_q;
    logic [WORD_LEN*CHAR_W-1:0] word_f;
    logic [WORD_LEN-1:0]        match;
    logic [WORD_LEN-1:0]        rev_next;
    logic                       any_hit;
    logic [3:0]                 mc_next;

    for (genvar i = 0; i < WORD_LEN; i++) begin : g_slot
        assign word_f[i*CHAR_W +: CHAR_W] = fold(word_in[i*CHAR_W +: CHAR_W]);

        slot_compare #(
            .CHAR_W    (CHAR_W),
            .FILL_CHAR (FILL_CHAR)
        ) u_slot (
            .stored   (word[i*CHAR_W +: CHAR_W]),
            .key      (key_q),
            .revealed (revealed[i]),
            .match    (match[i]),
            .disp     (disp_word[i*CHAR_W +: CHAR_W])
        );
    end

    assign any_hit  = |match;
    assign rev_next = revealed | match;
    // A hit never advances the counter; a miss saturates at the limit.
    assign mc_next  = any_hit ? miss_count :
                      (miss_count == MAX_MC) ? miss_count : miss_count + 4'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            word       <= '0;
            key_q      <= '0;
            revealed   <= '0;
            miss_count <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            if (load) begin
                word       <= word_f;
                revealed   <= '0;
                miss_count <= '0;
                state      <= S_PLAY;
            end else begin
                unique case (state)
                    S_PLAY: begin
                        if (key_valid) begin
                            key_q <= fold(key);
                            state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        revealed   <= rev_next;
                        miss_count <= mc_next;
                        hit        <= any_hit;
                        miss       <= !any_hit;
                        if (&rev_next)
                            state <= S_WIN;
                        else if (mc_next == MAX_MC)
                            state <= S_LOSE;
                        else
                            state <= S_PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign key_ready = (state == S_PLAY);

    always_comb begin
        status = ST_IDLE;
        unique case (state)
            S_IDLE:  status = ST_IDLE;
            S_PLAY:  status = ST_PLAY;
            S_CHECK: status = ST_PLAY;
            S_WIN:   status = ST_WIN;
            S_LOSE:  status = ST_LOSE;
            default: status = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_word_matcher.sv
// Scoreboard bench for word_matcher: guesses push expected results,
// a negedge monitor pops them whenever hit or miss pulses.
module tb_word_matcher;

    localparam logic [6:0] C_A  = 7'h41, C_B = 7'h42, C_C = 7'h43, C_D = 7'h44;
    localparam logic [6:0] C_E  = 7'h45, C_K = 7'h4B, C_O = 7'h4F, C_R = 7'h52;
    localparam logic [6:0] C_S  = 7'h53, C_W = 7'h57, C_Y = 7'h59, C_Z = 7'h5A;
    localparam logic [6:0] L_A  = 7'h61, L_B = 7'h62, L_C = 7'h63, L_O = 7'h6F;
    localparam logic [6:0] DSH  = 7'h2D;
    localparam logic [27:0] DASH4 = {4{7'h2D}};

    logic        clk = 1'b0;
    logic        rst, load, key_valid;
    logic [27:0] word_in;
    logic [6:0]  key;
    logic        key_ready, hit, miss;
    logic [27:0] disp_word;
    logic [3:0]  revealed, miss_count;
    logic [1:0]  status;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        hit;
        logic        miss;
        logic [3:0]  rev;
        logic [3:0]  mc;
        logic [1:0]  st;
        logic [27:0] disp;
    } exp_t;

    exp_t q[$];
    exp_t mon_e, mon_a;

    always #5 clk = ~clk;

    word_matcher dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .word_in    (word_in),
        .key_valid  (key_valid),
        .key        (key),
        .key_ready  (key_ready),
        .disp_word  (disp_word),
        .revealed   (revealed),
        .hit        (hit),
        .miss       (miss),
        .miss_count (miss_count),
        .status     (status)
    );

    function automatic logic [27:0] w4(input logic [6:0] s0, input logic [6:0] s1,
                                       input logic [6:0] s2, input logic [6:0] s3);
        return {s3, s2, s1, s0};
    endfunction

    always @(negedge clk) begin
        if (rst && (hit || miss)) begin
            mon_a = {hit, miss, revealed, miss_count, status, disp_word};
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL stray_pulse: got hit=%0b miss=%0b want no pulse", hit, miss);
            end else begin
                mon_e = q.pop_front();
                if (mon_a !== mon_e) begin
                    bad++;
                    $display("FAIL scoreboard: got %h want %h", mon_a, mon_e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (key_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got key_ready=0 want 1 within 20 cycles");
        end
    endtask

    task automatic guess(input logic [6:0] k, input logic h, input logic [3:0] r,
                         input logic [3:0] m, input logic [1:0] s, input logic [27:0] d);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        q.push_back({h, !h, r, m, s, d});
        key       = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic do_load(input logic [27:0] w);
        load    = 1'b1;
        word_in = w;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_ready"},  32'(key_ready), 32'd0);
        check({tag, "_rev"},    32'(revealed), 32'd0);
        check({tag, "_mc"},     32'(miss_count), 32'd0);
        check({tag, "_pulse"},  32'({hit, miss}), 32'd0);
        check({tag, "_disp"},   32'(disp_word), 32'(DASH4));
    endtask

    initial begin
        bit ok;
        rst = 1'b0; load = 1'b0; key_valid = 1'b0; key = '0; word_in = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;
        @(negedge clk);

        do_load(w4(C_A, C_B, C_C, C_A));
        @(negedge clk);
        check("load_status", 32'(status), 32'd1);
        check("load_ready",  32'(key_ready), 32'd1);
        check("load_disp",   32'(disp_word), 32'(DASH4));

        guess(C_A, 1, 4'b1001, 0, 1, w4(C_A, DSH, DSH, C_A));
        guess(L_B, 1, 4'b1011, 0, 1, w4(C_A, C_B, DSH, C_A));
        guess(C_C, 1, 4'b1111, 0, 2, w4(C_A, C_B, C_C, C_A));
        drain();
        check("win_status", 32'(status), 32'd2);
        check("win_ready",  32'(key_ready), 32'd0);
        key = C_Z; key_valid = 1'b1;
        repeat (3) @(negedge clk);
        key_valid = 1'b0;
        check("win_hold_status", 32'(status), 32'd2);
        check("win_hold_rev",    32'(revealed), 32'hF);

        do_load(w4(C_W, C_O, C_R, C_D));
        guess(L_O, 1, 4'b0010, 0, 1, w4(DSH, C_O, DSH, DSH));
        guess(C_O, 1, 4'b0010, 0, 1, w4(DSH, C_O, DSH, DSH));
        for (int i = 1; i <= 6; i++)
            guess(C_Z, 0, 4'b0010, 4'(i), (i == 6) ? 2'd3 : 2'd1, w4(DSH, C_O, DSH, DSH));
        drain();
        check("lose_status", 32'(status), 32'd3);
        check("lose_mc",     32'(miss_count), 32'd6);
        check("lose_ready",  32'(key_ready), 32'd0);
        key = C_Z; key_valid = 1'b1;
        repeat (3) @(negedge clk);
        key_valid = 1'b0;
        check("lose_hold_mc", 32'(miss_count), 32'd6);

        do_load(w4(L_A, L_B, L_C, L_A));
        guess(C_Z, 0, 4'b0000, 1, 1, DASH4);
        drain();
        key = C_K; key_valid = 1'b1; load = 1'b1; word_in = w4(C_K, C_E, C_Y, C_S);
        @(posedge clk);
        #1 key_valid = 1'b0; load = 1'b0;
        @(negedge clk);
        check("simul_mc",     32'(miss_count), 32'd0);
        check("simul_status", 32'(status), 32'd1);
        check("simul_ready",  32'(key_ready), 32'd1);
        drain();
        check("simul_rev", 32'(revealed), 32'd0);
        guess(C_K, 1, 4'b0001, 0, 1, w4(C_K, DSH, DSH, DSH));
        drain();

        wait_ready(ok);
        key = C_E; key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0; load = 1'b1; word_in = w4(L_A, L_B, L_C, L_A);
        @(posedge clk);
        #1 load = 1'b0;
        @(negedge clk);
        check("chk_load_rev",    32'(revealed), 32'd0);
        check("chk_load_mc",     32'(miss_count), 32'd0);
        check("chk_load_status", 32'(status), 32'd1);
        drain();
        guess(C_E, 0, 4'b0000, 1, 1, DASH4);
        guess(L_C, 1, 4'b0100, 1, 1, w4(DSH, DSH, C_C, DSH));
        drain();

        wait_ready(ok);
        key = C_A; key_valid = 1'b1;
        @(posedge clk);
        #1 key_valid = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        drain();

        check("queue_drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
